// File: rtl/alu_seq_ctrl.sv
// Sequencing controller in front of a combinational 32-bit ALU: issues one op, holds
// inputs for SETTLE_CYCLES, captures the result. `ALU_SEQ_WIDE_EN adds two-pass 64-bit arithmetic.
module alu_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_op_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic        req_cin_i,
`ifdef ALU_SEQ_WIDE_EN
    input  logic        req_wide_i,
    input  logic [31:0] req_a_hi_i,
    input  logic [31:0] req_b_hi_i,
`endif
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [5:0]  alu_opcode_o,
    output logic        alu_cin_o,
    input  logic [31:0] alu_ans_i,
    input  logic        alu_ans_opt_i,
    input  logic        alu_z_i,
    input  logic        alu_n_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_ans_o,
`ifdef ALU_SEQ_WIDE_EN
    output logic [31:0] rsp_ans_hi_o,
`endif
    output logic        rsp_opt_o,
    output logic        rsp_z_o,
    output logic        rsp_n_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE_LO = 2'd1,
        ST_DRIVE_HI = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 32'd1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [5:0]  alu_op_q, alu_op_d;
    logic        alu_cin_q, alu_cin_d;
    logic [31:0] rsp_ans_q, rsp_ans_d;
    logic        rsp_opt_q, rsp_opt_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_n_q, rsp_n_d;
    logic        rsp_err_q, rsp_err_d;
    logic        wide_s;
    logic        illegal_s;
`ifdef ALU_SEQ_WIDE_EN
    logic        wide_q, wide_d;
    logic [31:0] a_hi_q, a_hi_d;
    logic [31:0] b_hi_q, b_hi_d;
    logic [31:0] rsp_ans_hi_q, rsp_ans_hi_d;

    assign wide_s = req_wide_i;
`else
    assign wide_s = 1'b0;
`endif

    // Class 00 is never issued; wide passes are only meaningful for arithmetic.
    always_comb begin
        illegal_s = 1'b0;
        if (req_op_i[5:4] == 2'b00) begin
            illegal_s = 1'b1;
        end else if (wide_s && (req_op_i[5:4] != 2'b01)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        alu_cin_d = alu_cin_q;
        rsp_ans_d = rsp_ans_q;
        rsp_opt_d = rsp_opt_q;
        rsp_z_d   = rsp_z_q;
        rsp_n_d   = rsp_n_q;
        rsp_err_d = rsp_err_q;
`ifdef ALU_SEQ_WIDE_EN
        wide_d       = wide_q;
        a_hi_d       = a_hi_q;
        b_hi_d       = b_hi_q;
        rsp_ans_hi_d = rsp_ans_hi_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (illegal_s) begin
                        rsp_ans_d = 32'h0000_0000;
                        rsp_opt_d = 1'b0;
                        rsp_z_d   = 1'b0;
                        rsp_n_d   = 1'b0;
                        rsp_err_d = 1'b1;
`ifdef ALU_SEQ_WIDE_EN
                        rsp_ans_hi_d = 32'h0000_0000;
`endif
                        state_d   = ST_RESP;
                    end else begin
                        alu_a_d   = req_a_i;
                        alu_b_d   = req_b_i;
                        alu_op_d  = req_op_i;
                        alu_cin_d = req_cin_i;
                        cnt_d     = CNT_RELOAD;
`ifdef ALU_SEQ_WIDE_EN
                        wide_d    = req_wide_i;
                        a_hi_d    = req_a_hi_i;
                        b_hi_d    = req_b_hi_i;
`endif
                        state_d   = ST_DRIVE_LO;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE_LO: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_ans_d = alu_ans_i;
                    rsp_opt_d = alu_ans_opt_i;
                    rsp_z_d   = alu_z_i;
                    rsp_n_d   = alu_n_i;
                    rsp_err_d = 1'b0;
`ifdef ALU_SEQ_WIDE_EN
                    rsp_ans_hi_d = 32'h0000_0000;
                    if (wide_q) begin
                        // Carry/borrow of the low word chains into the high pass.
                        alu_a_d   = a_hi_q;
                        alu_b_d   = b_hi_q;
                        alu_cin_d = alu_ans_opt_i;
                        cnt_d     = CNT_RELOAD;
                        state_d   = ST_DRIVE_HI;
                    end else begin
                        state_d   = ST_RESP;
                    end
`else
                    state_d = ST_RESP;
`endif
                end
            end
`ifdef ALU_SEQ_WIDE_EN
            ST_DRIVE_HI: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_ans_hi_d = alu_ans_i;
                    rsp_opt_d    = alu_ans_opt_i;
                    rsp_z_d      = rsp_z_q & alu_z_i;
                    rsp_n_d      = alu_n_i;
                    state_d      = ST_RESP;
                end
            end
`endif
            ST_RESP: begin
                if (rsp_ready_i) begin
                    alu_op_d = 6'b000000;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_RESP;
                end
            end
            default: begin
                alu_op_d = 6'b000000;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            alu_a_q   <= 32'h0000_0000;
            alu_b_q   <= 32'h0000_0000;
            alu_op_q  <= 6'b000000;
            alu_cin_q <= 1'b0;
            rsp_ans_q <= 32'h0000_0000;
            rsp_opt_q <= 1'b0;
            rsp_z_q   <= 1'b0;
            rsp_n_q   <= 1'b0;
            rsp_err_q <= 1'b0;
`ifdef ALU_SEQ_WIDE_EN
            wide_q       <= 1'b0;
            a_hi_q       <= 32'h0000_0000;
            b_hi_q       <= 32'h0000_0000;
            rsp_ans_hi_q <= 32'h0000_0000;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            alu_cin_q <= alu_cin_d;
            rsp_ans_q <= rsp_ans_d;
            rsp_opt_q <= rsp_opt_d;
            rsp_z_q   <= rsp_z_d;
            rsp_n_q   <= rsp_n_d;
            rsp_err_q <= rsp_err_d;
`ifdef ALU_SEQ_WIDE_EN
            wide_q       <= wide_d;
            a_hi_q       <= a_hi_d;
            b_hi_q       <= b_hi_d;
            rsp_ans_hi_q <= rsp_ans_hi_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_op_q;
    assign alu_cin_o    = alu_cin_q;
    assign rsp_ans_o    = rsp_ans_q;
    assign rsp_opt_o    = rsp_opt_q;
    assign rsp_z_o      = rsp_z_q;
    assign rsp_n_o      = rsp_n_q;
    assign rsp_err_o    = rsp_err_q;
`ifdef ALU_SEQ_WIDE_EN
    assign rsp_ans_hi_o = rsp_ans_hi_q;
`endif

endmodule
